// File: rtl/output_grant_arbiter_if.sv
// Request/grant bundle between the input selectors and one output's grant stage.
// The master side raises requests and accepts; the slave side (the arbiter) grants.
interface output_grant_arbiter_if #(
    parameter int N = 24,
    parameter int P = 8
);
    localparam int QW = (P > 1) ? $clog2(P) : 1;

    logic [P*N-1:0] i_request;
    logic           i_accept;
    logic [N-1:0]   o_grant;
    logic           o_grant_valid;
    logic [QW-1:0]  o_grant_prio;
    logic           o_output_idle;

    modport master (
        output i_request, i_accept,
        input  o_grant, o_grant_valid, o_grant_prio, o_output_idle
    );

    modport slave (
        input  i_request, i_accept,
        output o_grant, o_grant_valid, o_grant_prio, o_output_idle
    );
endinterface

// File: rtl/output_grant_arbiter.sv
// Output-side grant stage of a flattened-priority iSLIP scheduler: strict priority
// across levels, round-robin within a level, output held busy for one cell per accept.
module output_grant_arbiter #(
    parameter int N           = 24,
    parameter int P           = 8,
    parameter int CELL_CYCLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output_grant_arbiter_if.slave  arb
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int QW = (P > 1) ? $clog2(P) : 1;
    localparam int CW = $clog2(CELL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr [P];
    logic [CW-1:0] cnt;
    logic [PW-1:0] g;
    logic [QW-1:0] q;

    logic [QW-1:0] arb_q;
    logic [PW-1:0] arb_g;
    logic          arb_hit;
    logic          arb_found;
    logic [N-1:0]  lvl_req;
    int            idx;

    // Highest requesting level wins outright; within it, scan circularly from its pointer.
    always_comb begin
        arb_q     = '0;
        arb_hit   = 1'b0;
        arb_g     = '0;
        arb_found = 1'b0;
        idx       = 0;
        for (int p = 0; p < P; p++) begin
            if (|arb.i_request[p*N +: N]) begin
                arb_q   = QW'(p);
                arb_hit = 1'b1;
            end
        end
        lvl_req = arb.i_request[int'(arb_q)*N +: N];
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr[arb_q]) + k;
            if (idx >= N) idx = idx - N;
            if (!arb_found && lvl_req[idx]) begin
                arb_g     = PW'(idx);
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (arb_hit) state_nxt = GRANT;
            GRANT:   state_nxt = arb.i_accept ? XFER : IDLE;
            XFER:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only, so they follow reset immediately.
    always_comb begin
        arb.o_grant       = '0;
        arb.o_grant_valid = 1'b0;
        arb.o_grant_prio  = '0;
        arb.o_output_idle = (state == IDLE);
        if (state == GRANT) begin
            arb.o_grant[g]    = 1'b1;
            arb.o_grant_valid = 1'b1;
            arb.o_grant_prio  = q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            g     <= '0;
            q     <= '0;
            for (int p = 0; p < P; p++) ptr[p] <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (arb_hit) begin
                        g <= arb_g;
                        q <= arb_q;
                    end
                end
                GRANT: begin
                    // Only the granted level's pointer advances, and only on accept.
                    if (arb.i_accept) begin
                        ptr[q] <= (int'(g) == N - 1) ? '0 : g + 1'b1;
                        cnt    <= CW'(CELL_CYCLES - 1);
                    end
                end
                XFER: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_output_grant_arbiter.sv
// Bench for output_grant_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural reference model.
module tb_output_grant_arbiter;
    localparam int N  = 24;
    localparam int P  = 8;
    localparam int CC = 4;
    localparam int QW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_grant_arbiter_if #(.N(N), .P(P)) arb();

    output_grant_arbiter #(.N(N), .P(P), .CELL_CYCLES(CC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .arb     (arb)
    );

    int pass_cnt = 0;
    int total    = 0;

    // Reference model: pointer per level, phase 0=free, 1=grant shown, 2=cell in flight.
    int m_ptr [P];
    int m_phase, m_g, m_q, m_busy;
    logic [N-1:0]  exp_grant;
    logic          exp_valid, exp_idle;
    logic [QW-1:0] exp_prio;

    task automatic model_outputs();
        exp_valid = (m_phase == 1);
        exp_idle  = (m_phase == 0);
        exp_grant = (m_phase == 1) ? (N'(1) << m_g) : '0;
        exp_prio  = (m_phase == 1) ? QW'(m_q) : '0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < P; p++) m_ptr[p] = 0;
        m_phase = 0; m_g = 0; m_q = 0; m_busy = 0;
        model_outputs();
    endtask

    task automatic model_tick(input logic [P*N-1:0] req, input logic acc);
        int lvl;
        int n;
        bit found;
        case (m_phase)
            0: begin
                lvl = -1;
                for (int p = 0; p < P; p++) if (req[p*N +: N] != '0) lvl = p;
                if (lvl >= 0) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        n = (m_ptr[lvl] + k) % N;
                        if (!found && req[lvl*N + n]) begin
                            m_g = n;
                            found = 1;
                        end
                    end
                    m_q = lvl;
                    m_phase = 1;
                end
            end
            1: begin
                if (acc) begin
                    m_ptr[m_q] = (m_g + 1) % N;
                    m_busy = CC;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
            default: begin
                m_busy--;
                if (m_busy == 0) m_phase = 0;
            end
        endcase
        model_outputs();
    endtask

    function automatic logic [P*N-1:0] rq(input int p, input int n);
        logic [P*N-1:0] r;
        r = '0;
        r[p*N + n] = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [P*N-1:0] req, input logic acc);
        arb.i_request = req;
        arb.i_accept  = acc;
        @(posedge clk);
        model_tick(req, acc);
        #1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_phase != 0 && guard < 50) begin
            drive('0, 1'b0);
            guard++;
        end
        total++;
        if (arb.o_output_idle !== 1'b1) $display("FAIL wait_idle: idle=%b want 1", arb.o_output_idle);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        arb.i_request = '0;
        arb.i_accept  = 1'b0;
        #2;
        total++; if (arb.o_grant !== '0)          $display("FAIL rst_grant: got %h want 0", arb.o_grant); else pass_cnt++;
        total++; if (arb.o_grant_valid !== 1'b0)  $display("FAIL rst_valid: got %b want 0", arb.o_grant_valid); else pass_cnt++;
        total++; if (arb.o_grant_prio !== '0)     $display("FAIL rst_prio: got %0d want 0", arb.o_grant_prio); else pass_cnt++;
        total++; if (arb.o_output_idle !== 1'b1)  $display("FAIL rst_idle: got %b want 1", arb.o_output_idle); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(rq(3, 5), 1'b0);
        total++; if (arb.o_grant !== 24'h000020) $display("FAIL single_grant: got %h want 000020", arb.o_grant); else pass_cnt++;
        total++; if (arb.o_grant_prio !== 3'd3)  $display("FAIL single_prio: got %0d want 3", arb.o_grant_prio); else pass_cnt++;
        total++; if (arb.o_output_idle !== 1'b0) $display("FAIL single_idle_t1: got %b want 0", arb.o_output_idle); else pass_cnt++;
        drive('0, 1'b1);
        total++; if (arb.o_output_idle !== 1'b0) $display("FAIL single_idle_t2: got %b want 0", arb.o_output_idle); else pass_cnt++;
        for (int i = 0; i < CC - 1; i++) begin
            drive('0, 1'b0);
            total++; if (arb.o_output_idle !== 1'b0) $display("FAIL single_idle_xfer%0d: got %b want 0", i, arb.o_output_idle); else pass_cnt++;
        end
        drive('0, 1'b0);
        total++; if (arb.o_output_idle !== 1'b1) $display("FAIL single_idle_back: got %b want 1", arb.o_output_idle); else pass_cnt++;
        // pointer of level 3 now sits at 6, so 6 beats 5
        drive(rq(3, 5) | rq(3, 6), 1'b0);
        total++; if (arb.o_grant !== (N'(1) << 6)) $display("FAIL single_ptr6: got %h want %h", arb.o_grant, N'(1) << 6); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_priority();
        drive(rq(1, 2) | rq(6, 10), 1'b0);
        total++; if (arb.o_grant !== (N'(1) << 10)) $display("FAIL prio_grant: got %h want %h", arb.o_grant, N'(1) << 10); else pass_cnt++;
        total++; if (arb.o_grant_prio !== 3'd6)     $display("FAIL prio_level: got %0d want 6", arb.o_grant_prio); else pass_cnt++;
        drive('0, 1'b1);
        wait_idle();
        drive(rq(1, 2) | rq(1, 20), 1'b0);
        total++; if (arb.o_grant !== (N'(1) << 2)) $display("FAIL prio_ptr1: got %h want %h", arb.o_grant, N'(1) << 2); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_round_robin();
        int want [4] = '{0, 7, 23, 0};
        logic [P*N-1:0] req;
        int guard;
        req = rq(0, 0) | rq(0, 7) | rq(0, 23);
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            do begin
                drive(req, 1'b0);
                guard++;
            end while (m_phase != 1 && guard < 20);
            total++; if (arb.o_grant !== (N'(1) << want[i])) $display("FAIL rr_grant%0d: got %h want %h", i, arb.o_grant, N'(1) << want[i]); else pass_cnt++;
            drive(req, 1'b1);
        end
        wait_idle();
    endtask

    task automatic test_no_accept();
        drive(rq(2, 7), 1'b0);
        total++; if (arb.o_grant !== (N'(1) << 7)) $display("FAIL noacc_grant: got %h want %h", arb.o_grant, N'(1) << 7); else pass_cnt++;
        drive(rq(2, 7), 1'b0);
        total++; if (arb.o_output_idle !== 1'b1)  $display("FAIL noacc_idle: got %b want 1", arb.o_output_idle); else pass_cnt++;
        total++; if (arb.o_grant_valid !== 1'b0)  $display("FAIL noacc_valid: got %b want 0", arb.o_grant_valid); else pass_cnt++;
        drive(rq(2, 7), 1'b0);
        total++; if (arb.o_grant !== (N'(1) << 7)) $display("FAIL noacc_regrant: got %h want %h", arb.o_grant, N'(1) << 7); else pass_cnt++;
        drive('0, 1'b0);
        drive(rq(2, 3) | rq(2, 7), 1'b0);
        total++; if (arb.o_grant !== (N'(1) << 3)) $display("FAIL noacc_ptr2: got %h want %h", arb.o_grant, N'(1) << 3); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_lockout();
        logic [P*N-1:0] hi;
        hi = rq(7, 9);
        drive(rq(0, 4), 1'b0);
        drive(hi, 1'b1);
        for (int i = 0; i < CC - 1; i++) begin
            drive(hi, 1'b1);
            total++; if (arb.o_grant_valid !== 1'b0) $display("FAIL lock_valid%0d: got %b want 0", i, arb.o_grant_valid); else pass_cnt++;
        end
        drive(hi, 1'b0);
        total++; if (arb.o_output_idle !== 1'b1) $display("FAIL lock_idle: got %b want 1", arb.o_output_idle); else pass_cnt++;
        drive(hi, 1'b0);
        total++; if (arb.o_grant !== (N'(1) << 9)) $display("FAIL lock_grant: got %h want %h", arb.o_grant, N'(1) << 9); else pass_cnt++;
        total++; if (arb.o_grant_prio !== 3'd7)    $display("FAIL lock_prio: got %0d want 7", arb.o_grant_prio); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_random();
        logic [P*N-1:0] req;
        logic acc;
        int k;
        for (int c = 0; c < 400; c++) begin
            req = '0;
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) req[$urandom_range(0, P*N-1)] = 1'b1;
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 2)*N + $urandom_range(0, N-1)] = 1'b1;
            acc = ($urandom_range(0, 3) != 0);
            drive(req, acc);
            total++; if (arb.o_grant !== exp_grant)       $display("FAIL rnd_grant c%0d: got %h want %h", c, arb.o_grant, exp_grant); else pass_cnt++;
            total++; if (arb.o_grant_valid !== exp_valid) $display("FAIL rnd_valid c%0d: got %b want %b", c, arb.o_grant_valid, exp_valid); else pass_cnt++;
            total++; if (arb.o_grant_prio !== exp_prio)   $display("FAIL rnd_prio c%0d: got %0d want %0d", c, arb.o_grant_prio, exp_prio); else pass_cnt++;
            total++; if (arb.o_output_idle !== exp_idle)  $display("FAIL rnd_idle c%0d: got %b want %b", c, arb.o_output_idle, exp_idle); else pass_cnt++;
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_xfer();
        drive(rq(0, 0), 1'b0);
        total++; if (arb.o_grant !== 24'h000001) $display("FAIL mid_pre_grant: got %h want 000001", arb.o_grant); else pass_cnt++;
        drive('0, 1'b1);
        drive('0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        total++; if (arb.o_grant !== '0)         $display("FAIL mid_rst_grant: got %h want 0", arb.o_grant); else pass_cnt++;
        total++; if (arb.o_grant_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", arb.o_grant_valid); else pass_cnt++;
        total++; if (arb.o_grant_prio !== '0)    $display("FAIL mid_rst_prio: got %0d want 0", arb.o_grant_prio); else pass_cnt++;
        total++; if (arb.o_output_idle !== 1'b1) $display("FAIL mid_rst_idle: got %b want 1", arb.o_output_idle); else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // pointer of level 0 was 1 before reset; after reset input 0 wins again
        drive(rq(0, 0) | rq(0, 1), 1'b0);
        total++; if (arb.o_grant !== 24'h000001) $display("FAIL mid_post_grant: got %h want 000001", arb.o_grant); else pass_cnt++;
        total++; if (arb.o_grant_prio !== '0)    $display("FAIL mid_post_prio: got %0d want 0", arb.o_grant_prio); else pass_cnt++;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_no_accept();
        test_lockout();
        test_random();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/output_grant_arbiter.md
# output_grant_arbiter

Output-side grant stage of the flattened-priority iSLIP scheduler: one instance per output port. It collects the per-priority request bits that every input's priority selector raises toward this output and grants one input at the highest requested priority, round-robin within that level. It holds the output busy for one cell time after the grant is accepted, and drives the output-idle status back into every input's selector.

## Interface
Parameters:
- N, 24, number of input ports.
- P, 8, number of priority levels; index P-1 is highest.
- CELL_CYCLES, 4, cycles the output is occupied per accepted cell; must be ≥1.
- PW, clog2(N) (min 1), pointer width; local.
- QW, clog2(P) (min 1), priority index width; local.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_request  in  P*N  request from input n at priority p on bit p*N+n.
- i_accept  in  1  granted input accepts this grant; sampled only in GRANT.
- o_grant  out  N  one-hot granted input; all-zero when o_grant_valid=0.
- o_grant_valid  out  1  grant presented this cycle.
- o_grant_prio  out  QW  priority of presented grant; 0 when o_grant_valid=0.
- o_output_idle  out  1  output free for new requests; 1 only in IDLE.

## Operation
- State: FSM {IDLE, GRANT, XFER}; ptr[p] (PW bits) per priority; cnt (clog2(CELL_CYCLES+1) bits); registered grant index g and priority q.
- IDLE:
  - o_output_idle=1.
  - If i_request has any bit set: q = highest p with any request at level p; g = first n with request[q*N+n] set, scanning circularly from ptr[q] (ptr[q] itself first, wrap N-1→0); go GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - o_grant_valid=1, o_grant=1<<g, o_grant_prio=q; requests ignored.
  - i_accept=1: ptr[q] ← (g==N-1) ? 0 : g+1; cnt ← CELL_CYCLES-1; go XFER.
  - i_accept=0: no pointer change; back to IDLE (re-arbitrate).
- XFER:
  - o_output_idle=0, grant outputs zero; i_request and i_accept ignored.
  - cnt==0 → IDLE; else cnt ← cnt-1.
- Only the granted level's pointer moves, and only on accept (iSLIP desynchronisation rule). Other levels' pointers never change.
- ptr values are always in [0, N-1]; N need not be a power of two.
- Requests at lower levels are masked whenever any higher level requests, with no starvation guard.
- Reset (async, any state): state=IDLE, all ptr=0, cnt=0, g=0, q=0. Outputs go to reset values immediately: o_grant=0, o_grant_valid=0, o_grant_prio=0, o_output_idle=1.

## Timing
- Request seen in IDLE at cycle t → grant visible in cycle t+1 (GRANT lasts exactly one cycle).
- Accept at t+1 → XFER in cycles t+2 … t+1+CELL_CYCLES → IDLE at t+2+CELL_CYCLES. Earliest next grant is at t+3+CELL_CYCLES.
- No accept at t+1 → IDLE at t+2, next grant at t+3.
- o_output_idle is a registered-state decode: it falls the cycle after a request is seen and rises the cycle the FSM re-enters IDLE.
- Request bits toggling during GRANT/XFER have no effect. A request withdrawn in the same cycle IDLE samples it is not granted.
- i_accept asserted outside GRANT has no effect.

## Test plan
- Reset: assert i_rst_n=0 mid-XFER → same cycle o_grant=0, o_grant_valid=0, o_grant_prio=0, o_output_idle=1. After release, a request from input 0 at prio 0 is granted (ptr reset to 0).
- Single request: input 5, prio 3 at cycle t; accept at t+1 → o_grant=0x000020 and o_grant_prio=3 at t+1. o_output_idle=0 for cycles t+1…t+5 and 1 at t+6; ptr[3]=6.
- Priority: input 2 at prio 1 plus input 10 at prio 6 → o_grant=1<<10, o_grant_prio=6; ptr[1] stays 0.
- Round-robin with wrap: inputs 0, 7, 23 request prio 0 continuously, always accepting → grant sequence 0, 7, 23, 0, with ptr[0] going 1, 8, 0, 1.
- No accept: input 7 at prio 2, i_accept=0 → grant at t+1, IDLE at t+2, ptr[2] unchanged. Input 7 is regranted at t+3; inputs 3 and 7 both requesting are granted 3 first (ptr[2]=0).
- Lockout: after an accept, new higher-priority requests during XFER are not granted until CELL_CYCLES+1 cycles after the grant cycle.
